// File: rtl/calc1_port_driver.sv
// calc1_port_driver: accepts one operation over a valid/ready handshake,
// plays it into calc1 as a command cycle followed by an operand-2 cycle,
// waits for calc1's answer (or gives up after TIMEOUT cycles) and presents
// the result over a valid/ready response handshake.
module calc1_port_driver #(
  parameter int TIMEOUT = 64,
  parameter int GAP     = 0
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  output logic [0:3]  cmd_in,
  output logic [0:31] data_in,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic [15:0] txn_count,
  output logic [7:0]  timeout_count
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_OP2,
    S_WAIT,
    S_DONE,
    S_GAP
  } state_t;

  state_t state;
  state_t next_state;

  // cmd and op1 are captured straight into cmd_in/data_in on the accept
  // edge, so only op2 needs its own holding register
  logic [0:31]       op2_hold;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              got_resp;
  logic              timed_out;

  // next-state decode; a timeout only fires when calc1 stayed silent on the last counted cycle
  always_comb begin
    next_state = state;
    got_resp   = (out_resp != 2'b00);
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) next_state = S_CMD;
      end
      S_CMD:  next_state = S_OP2;
      S_OP2:  next_state = S_WAIT;
      S_WAIT: begin
        if (got_resp) begin
          next_state = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          next_state = S_DONE;
          timed_out  = 1'b1;
        end
      end
      S_DONE: begin
        if (rsp_ready) next_state = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // state register plus handshake flags registered from the upcoming state
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == S_IDLE);
      rsp_valid <= (next_state == S_DONE);
    end
  end

  // calc1 input drive: command+op1 in the CMD cycle, op2 in the OP2 cycle, zero otherwise
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      cmd_in   <= '0;
      data_in  <= '0;
      op2_hold <= '0;
    end else begin
      cmd_in  <= '0;
      data_in <= '0;
      if (state == S_IDLE && next_state == S_CMD) begin
        cmd_in   <= req_cmd;
        data_in  <= req_op1;
        op2_hold <= req_op2;
      end else if (next_state == S_OP2) begin
        data_in <= op2_hold;
      end
    end
  end

  // wait and gap counters, each cleared in the state just before it is used
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (state == S_OP2) begin
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == S_DONE) begin
        gap_cnt <= '0;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // response capture when leaving WAIT; held untouched through DONE regardless of out_resp
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rsp_resp    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else if (state == S_WAIT && next_state == S_DONE) begin
      rsp_resp    <= timed_out ? 2'b00 : out_resp;
      rsp_data    <= timed_out ? 32'h0 : out_data;
      rsp_timeout <= timed_out;
    end
  end

  // statistics: transactions wrap, timeouts saturate
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      txn_count     <= '0;
      timeout_count <= '0;
    end else if (state == S_DONE && rsp_ready) begin
      txn_count <= txn_count + 16'd1;
      if (rsp_timeout && timeout_count != 8'hFF) begin
        timeout_count <= timeout_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// tb_calc1_port_driver: directed bench with a small calc1 model and a
// scoreboard queue of expected responses.
module tb_calc1_port_driver;

  logic        c_clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic [0:3]  cmd_in;
  logic [0:31] data_in;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic [15:0] txn_count;
  logic [7:0]  timeout_count;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic        to;
  } exp_t;

  exp_t scoreboard[$];
  int   total = 0;
  int   bad = 0;
  int   exp_txn = 0;
  int   exp_to = 0;

  calc1_port_driver #(.TIMEOUT(64), .GAP(3)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_op1(req_op1),
    .req_op2(req_op2),
    .cmd_in(cmd_in),
    .data_in(data_in),
    .out_resp(out_resp),
    .out_data(out_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp),
    .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout),
    .txn_count(txn_count),
    .timeout_count(timeout_count)
  );

  // free-running clock
  initial begin
    c_clk = 1'b0;
    forever #5 c_clk = ~c_clk;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t calc_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic [32:0] wide;
    r.to = 1'b0;
    case (cmd)
      4'd1: begin
        wide   = {1'b0, a} + {1'b0, b};
        r.data = wide[31:0];
        r.resp = wide[32] ? 2'd2 : 2'd1;
      end
      4'd2: begin
        r.data = a - b;
        r.resp = (b > a) ? 2'd2 : 2'd1;
      end
      4'd5: begin
        r.data = a << b[4:0];
        r.resp = 2'd1;
      end
      4'd6: begin
        r.data = a >> b[4:0];
        r.resp = 2'd1;
      end
      default: begin
        r.data = 32'h0;
        r.resp = 2'd3;
      end
    endcase
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // present a request, then follow the CMD/OP2 drive into the first WAIT cycle
  task automatic apply_request(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge c_clk);
      n++;
    end
    check_output("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_op1   = a;
    req_op2   = b;
    @(negedge c_clk);
    req_valid = 1'b0;
    req_cmd   = '0;
    req_op1   = '0;
    req_op2   = '0;
    check_output("cmd_phase_cmd", {28'd0, cmd_in}, {28'd0, cmd});
    check_output("cmd_phase_data", data_in, a);
    @(negedge c_clk);
    check_output("op2_phase_cmd", {28'd0, cmd_in}, 32'd0);
    check_output("op2_phase_data", data_in, b);
    @(negedge c_clk);
    check_output("wait_phase_data", data_in, 32'd0);
  endtask

  // calc1 model answer after a number of silent WAIT cycles
  task automatic calc_respond(input int delay, input exp_t r);
    repeat (delay) @(negedge c_clk);
    out_resp = r.resp;
    out_data = r.data;
    @(negedge c_clk);
    out_resp = '0;
    out_data = '0;
  endtask

  // wait for rsp_valid, score it against the queue head, then let the accept edge pass
  task automatic collect_response(output int cycles);
    exp_t e;
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge c_clk);
      n++;
    end
    cycles = n;
    check_output("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    if (rsp_valid && scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      check_output("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
      check_output("rsp_data", rsp_data, e.data);
      check_output("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
      if (!rsp_ready) rsp_ready = 1'b1;
      @(negedge c_clk);
      exp_txn = (exp_txn + 1) & 16'hFFFF;
      if (e.to && exp_to < 255) exp_to++;
      check_output("txn_count", {16'd0, txn_count}, exp_txn);
      check_output("timeout_count", {24'd0, timeout_count}, exp_to);
      check_output("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    exp_t e;
    int cyc;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_cmd   = '0;
    req_op1   = '0;
    req_op2   = '0;
    out_resp  = '0;
    out_data  = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge c_clk);
    reset = 1'b0;
    @(negedge c_clk);

    $display("[TB] reset state");
    check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("rst_cmd_in", {28'd0, cmd_in}, 32'd0);
    check_output("rst_data_in", data_in, 32'd0);
    check_output("rst_txn_count", {16'd0, txn_count}, 32'd0);

    $display("[TB] single add, answer after 3 WAIT cycles");
    e = calc_model(4'd1, 32'd1, 32'd0);
    scoreboard.push_back(e);
    apply_request(4'd1, 32'd1, 32'd0);
    calc_respond(3, e);
    collect_response(cyc);
    check_output("gap_req_ready", {31'd0, req_ready}, 32'd0);

    $display("[TB] walking-bit adds");
    for (int k = 0; k < 31; k++) begin
      e = calc_model(4'd1, 32'd1 << k, 32'd0);
      scoreboard.push_back(e);
      apply_request(4'd1, 32'd1 << k, 32'd0);
      calc_respond(0, e);
      collect_response(cyc);
    end

    $display("[TB] timeout");
    e = '{resp: 2'd0, data: 32'd0, to: 1'b1};
    scoreboard.push_back(e);
    apply_request(4'd1, 32'd5, 32'd6);
    collect_response(cyc);
    check_output("timeout_wait_cycles", cyc, 32'd64);

    $display("[TB] response on the last counted WAIT cycle");
    e = calc_model(4'd6, 32'h100, 32'd4);
    scoreboard.push_back(e);
    apply_request(4'd6, 32'h100, 32'd4);
    calc_respond(63, e);
    collect_response(cyc);

    $display("[TB] backpressure with a spurious out_resp in DONE");
    rsp_ready = 1'b0;
    e = calc_model(4'd2, 32'd3, 32'd5);
    scoreboard.push_back(e);
    apply_request(4'd2, 32'd3, 32'd5);
    calc_respond(1, e);
    for (int i = 0; i < 10; i++) begin
      check_output("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_output("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check_output("bp_rsp_data", rsp_data, e.data);
      check_output("bp_rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
      if (i == 2) begin
        out_resp = 2'd2;
        out_data = 32'hDEAD;
      end else begin
        out_resp = '0;
        out_data = '0;
      end
      @(negedge c_clk);
    end
    rsp_ready = 1'b1;
    collect_response(cyc);

    $display("[TB] reset during CMD clears calc1 drive at once");
    repeat (4) @(negedge c_clk);
    req_valid = 1'b1;
    req_cmd   = 4'd6;
    req_op1   = 32'h1234;
    req_op2   = 32'd1;
    @(negedge c_clk);
    req_valid = 1'b0;
    check_output("pre_rst_cmd_in", {28'd0, cmd_in}, 32'd6);
    #2 reset = 1'b1;
    #1;
    check_output("async_rst_cmd_in", {28'd0, cmd_in}, 32'd0);
    check_output("async_rst_data_in", data_in, 32'd0);
    exp_txn = 0;
    exp_to  = 0;
    @(negedge c_clk);
    reset = 1'b0;

    $display("[TB] reset mid-WAIT");
    e = calc_model(4'd1, 32'd10, 32'd20);
    apply_request(4'd1, 32'd10, 32'd20);
    repeat (5) @(negedge c_clk);
    #2 reset = 1'b1;
    #1;
    check_output("wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_output("wait_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("wait_rst_txn_count", {16'd0, txn_count}, 32'd0);
    check_output("wait_rst_timeout_count", {24'd0, timeout_count}, 32'd0);
    @(negedge c_clk);
    reset = 1'b0;
    out_resp = e.resp;
    out_data = e.data;
    repeat (3) begin
      @(negedge c_clk);
      check_output("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    out_resp = '0;
    out_data = '0;
    e = calc_model(4'd5, 32'd3, 32'd4);
    scoreboard.push_back(e);
    apply_request(4'd5, 32'd3, 32'd4);
    calc_respond(2, e);
    collect_response(cyc);

    $display("[TB] GAP window with stale out_resp");
    out_resp = 2'd1;
    out_data = 32'h77;
    for (int i = 0; i < 3; i++) begin
      check_output("gap_low", {31'd0, req_ready}, 32'd0);
      check_output("gap_no_rsp", {31'd0, rsp_valid}, 32'd0);
      @(negedge c_clk);
    end
    out_resp = '0;
    out_data = '0;
    check_output("gap_end_ready", {31'd0, req_ready}, 32'd1);
    check_output("gap_end_no_rsp", {31'd0, rsp_valid}, 32'd0);
    e = calc_model(4'd9, 32'd1, 32'd2);
    scoreboard.push_back(e);
    apply_request(4'd9, 32'd1, 32'd2);
    calc_respond(0, e);
    collect_response(cyc);
    e = calc_model(4'd1, 32'hFFFF_FFFF, 32'd2);
    scoreboard.push_back(e);
    apply_request(4'd1, 32'hFFFF_FFFF, 32'd2);
    calc_respond(4, e);
    collect_response(cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
